gray_ptr_gen: RTL and testbench
===============================

# gray_ptr_gen

Registered binary-to-Gray pointer generator for the write and read sides of asynchronous FIFOs. It keeps a binary count and advances it on request. On every change it presents the matching Gray code from a register, so that a synchronizer in the other clock domain only ever samples a glitch-free, single-bit-change value. It is the source-domain counterpart of the Gray-to-binary converter used on the receiving side of the crossing.

## Interface
- DATA_WIDTH, 8, pointer width in bits; legal range ≥ 2
- clk_i  input  1  pointer-domain clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset; deassertion is synchronous to clk_i externally
- clr_i  input  1  synchronous clear of the pointer to zero
- load_i  input  1  synchronous load of load_bin_i
- load_bin_i  input  DATA_WIDTH  binary value taken when load_i is high
- inc_i  input  1  advance the pointer by one
- bin_o  output  DATA_WIDTH  registered binary pointer
- gray_o  output  DATA_WIDTH  registered Gray pointer; always equals bin_o ^ (bin_o >> 1)
- gray_next_o  output  DATA_WIDTH  combinational Gray value that gray_o will take at the next edge, for full/empty look-ahead
- wrap_o  output  1  registered one-cycle pulse: the pointer wrapped from all-ones to zero by increment
- chg_o  output  1  registered one-cycle pulse: gray_o took a new value at the last edge

## Operation
- **Reset (rst_n_i low, any time, asynchronous):** bin_o = 0, gray_o = 0, wrap_o = 0, chg_o = 0. gray_next_o follows the combinational rules from the reset state.
- **Next-binary selection, strict priority:**
  - clr_i → 0
  - else load_i → load_bin_i
  - else inc_i → bin_o + 1, modulo 2^DATA_WIDTH; the carry out is discarded
  - else hold bin_o
- **Gray encoding:** next_gray = next_bin ^ (next_bin >> 1). gray_next_o = next_gray. gray_o is registered from next_gray, never derived combinationally from bin_o.
- **wrap_o:** set for one cycle when inc_i was the winning operation and bin_o was all-ones. It is not asserted when clr_i or load_i produce zero.
- **chg_o:** set for one cycle when the registered next_gray differs from the previous gray_o.
  - A load of the current value gives chg_o = 0.
  - A clear while already at zero gives chg_o = 0.
- **Bit-change guarantee:**
  - An increment changes exactly one bit of gray_o.
  - Clear and load may change several bits. The owning FIFO is responsible for using them only while the far domain is quiescent.
- The block has no other internal state. It is a single-state datapath; wrap_o and chg_o are the only event flags.

## Timing
- Latency is one cycle. Controls sampled at edge N are visible on bin_o, gray_o, wrap_o and chg_o after edge N.
- gray_next_o has zero latency. It depends on clr_i, load_i, load_bin_i, inc_i and bin_o in the same cycle.
- Continuous inc_i gives one increment per cycle, with no bubbles.
- **Simultaneous controls:** the priority above resolves them. For example, clr_i = 1 and inc_i = 1 at bin_o = all-ones gives bin_o = 0 and wrap_o = 0.
- **Reset mid-operation:** outputs are forced to zero immediately. After deassertion the first edge behaves as from the reset state.
- wrap_o and chg_o are never asserted on the first edge after reset unless an operation at that edge causes them.

## Test plan
- **Reset:** DATA_WIDTH = 4; hold rst_n_i low while inc_i = 1 → bin_o = 0, gray_o = 0, wrap_o = 0, chg_o = 0 throughout.
- **Full sweep:** DATA_WIDTH = 4, inc_i held high for 17 cycles.
  - gray_o must step 0, 1, 3, 2, 6, 7, 5, 4, C, D, F, E, A, B, 9, 8, 0.
  - Every step differs from the previous one in exactly one bit; chg_o = 1 each cycle.
  - wrap_o pulses only on the 15 → 0 edge.
- **Load:** load_i = 1, load_bin_i = 0xA → next edge bin_o = A, gray_o = F, chg_o = 1.
  - Repeat the same load → chg_o = 0.
  - Then inc_i → bin_o = B, gray_o = E.
- **Priority:** bin_o = F with clr_i = load_i = inc_i = 1 → bin_o = 0, wrap_o = 0, chg_o = 1.
  - Next cycle, load_i = inc_i = 1 with load_bin_i = 5 → bin_o = 5, gray_o = 7.
- **Look-ahead:** at bin_o = 7 with inc_i = 1 → gray_next_o = C in the same cycle; gray_o = C after the edge.
  - With inc_i = 0 → gray_next_o = 4, equal to gray_o.
- **Async reset mid-count:** pull rst_n_i low between edges at bin_o = 9 → outputs reach 0 before the next edge.
  - After release with inc_i = 1 → bin_o = 1, gray_o = 1.

Source files
------------

// File: rtl/gray_ptr_gen.sv
// Registered binary/Gray pointer for the source side of an asynchronous FIFO crossing.
// gray_o is always loaded from a register so the far-domain synchronizer never sees decode glitches.
module gray_ptr_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_bin_i,
  input  logic                  inc_i,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic [DATA_WIDTH-1:0] gray_o,
  output logic [DATA_WIDTH-1:0] gray_next_o,
  output logic                  wrap_o,
  output logic                  chg_o
);

  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1'b1);
  endfunction

  logic [DATA_WIDTH-1:0] bin_r;
  logic [DATA_WIDTH-1:0] gray_r;
  logic                  wrap_r;
  logic                  chg_r;
  logic [DATA_WIDTH-1:0] next_bin_s;
  logic [DATA_WIDTH-1:0] next_gray_s;
  logic                  next_wrap_s;
  logic                  next_chg_s;

  // Next-pointer selection: clear beats load beats increment; wrap only counts for increments.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    if (clr_i) begin
      next_bin_s = ZERO;
    end else if (load_i) begin
      next_bin_s = load_bin_i;
    end else if (inc_i) begin
      next_bin_s  = bin_r + ONE;
      next_wrap_s = &bin_r;
    end else begin
      next_bin_s = bin_r;
    end
  end

  // Gray look-ahead and change detection against the currently presented code.
  always_comb begin
    next_gray_s = bin2gray(next_bin_s);
    next_chg_s  = (next_gray_s != gray_r);
  end

  // Pointer and event-flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_r  <= ZERO;
      gray_r <= ZERO;
      wrap_r <= 1'b0;
      chg_r  <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= next_gray_s;
      wrap_r <= next_wrap_s;
      chg_r  <= next_chg_s;
    end
  end

  assign bin_o       = bin_r;
  assign gray_o      = gray_r;
  assign gray_next_o = next_gray_s;
  assign wrap_o      = wrap_r;
  assign chg_o       = chg_r;

endmodule

// File: tb/tb_gray_ptr_gen.sv
// Directed bench for gray_ptr_gen at DATA_WIDTH = 4 with hand-computed expectations.
module tb_gray_ptr_gen;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_bin;
  logic       inc;
  logic [3:0] bin;
  logic [3:0] gray;
  logic [3:0] gray_next;
  logic       wrap;
  logic       chg;

  int errors = 0;
  int checks = 0;

  gray_ptr_gen #(.DATA_WIDTH(4)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .clr_i      (clr),
    .load_i     (load),
    .load_bin_i (load_bin),
    .inc_i      (inc),
    .bin_o      (bin),
    .gray_o     (gray),
    .gray_next_o(gray_next),
    .wrap_o     (wrap),
    .chg_o      (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                             input logic ew, input logic ec);
    check({tag, ".bin"},  {4'h0, bin},  {4'h0, eb});
    check({tag, ".gray"}, {4'h0, gray}, {4'h0, eg});
    check({tag, ".wrap"}, {7'h0, wrap}, {7'h0, ew});
    check({tag, ".chg"},  {7'h0, chg},  {7'h0, ec});
  endtask

  logic [3:0] gtab [16];
  logic [3:0] prev;

  initial begin
    gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_bin = 4'h0; inc = 1'b1;

    // reset held with inc active
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    end
    check("reset.gray_next", {4'h0, gray_next}, 8'h01);
    rst_n = 1'b1;

    // full sweep
    prev = 4'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_state($sformatf("sweep%0d", i), 4'(i + 1), gtab[i], (i == 15), 1'b1);
      check($sformatf("sweep%0d.onebit", i), 8'($countones(gray ^ prev)), 8'h01);
      prev = gray;
    end

    // load, repeated load, then increment
    inc = 1'b0; load = 1'b1; load_bin = 4'hA;
    tick();
    check_state("load", 4'hA, 4'hF, 1'b0, 1'b1);
    tick();
    check_state("reload", 4'hA, 4'hF, 1'b0, 1'b0);
    load = 1'b0; inc = 1'b1;
    tick();
    check_state("load_inc", 4'hB, 4'hE, 1'b0, 1'b1);

    // priority at all-ones
    inc = 1'b0; load = 1'b1; load_bin = 4'hF;
    tick();
    check_state("load_f", 4'hF, 4'h8, 1'b0, 1'b1);
    clr = 1'b1; load = 1'b1; inc = 1'b1; load_bin = 4'h3;
    tick();
    check_state("prio_clr", 4'h0, 4'h0, 1'b0, 1'b1);
    load = 1'b0; inc = 1'b0;
    tick();
    check_state("clr_at_zero", 4'h0, 4'h0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b1; inc = 1'b1; load_bin = 4'h5;
    tick();
    check_state("prio_load", 4'h5, 4'h7, 1'b0, 1'b1);

    // look-ahead
    inc = 1'b0; load = 1'b1; load_bin = 4'h7;
    tick();
    load = 1'b0; inc = 1'b0;
    #1;
    check("la_hold.gray_next", {4'h0, gray_next}, 8'h04);
    check("la_hold.gray", {4'h0, gray}, 8'h04);
    inc = 1'b1;
    #1;
    check("la_inc.gray_next", {4'h0, gray_next}, 8'h0C);
    check("la_inc.gray", {4'h0, gray}, 8'h04);
    tick();
    check_state("la_edge", 4'h8, 4'hC, 1'b0, 1'b1);

    // async reset mid-count
    inc = 1'b0; load = 1'b1; load_bin = 4'h9;
    tick();
    check_state("pre_areset", 4'h9, 4'hD, 1'b0, 1'b1);
    load = 1'b0; inc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_state("areset", 4'h0, 4'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    check_state("post_areset", 4'h1, 4'h1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
